fir_filter_param: RTL and testbench

FIR_FILTER_PARAM -- requirements
Module: fir_filter_param

---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_filter_param_fsm.sv | 44 ++++
 rtl/fir_filter_param.sv | 125 ++++++++++++
 tb/tb_fir_filter_param.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the parameterised FIR filter.
// Holds the control FSM state encoding and accumulator/index width rules.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } fir_state_t;

    function automatic int idx_w(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    function automatic int acc_w(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_filter_param_fsm.sv
// Control sequencer for the FIR filter: accept, multiply-accumulate, output.
// load_out is a registered pulse so the result lands TAPS+1 cycles after accept.
module fir_filter_param_fsm
    import fir_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       accept,
    input  logic       last_tap,
    input  logic       out_fire,
    output fir_state_t state,
    output logic       mac_en,
    output logic       load_out
);

    fir_state_t state_q;
    fir_state_t state_d;
    logic       load_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= (state_q == MAC) && last_tap;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)   state_d = MAC;
            MAC:     if (last_tap) state_d = OUT;
            OUT:     if (out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign state    = state_q;
    assign mac_en   = (state_q == MAC);
    assign load_out = load_q;

endmodule

// File: rtl/fir_filter_param.sv
// Sequential single-multiplier FIR filter with writable coefficients,
// rounding/saturating output stage and valid/ready handshakes on both sides.
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        x_data,
    input  logic                     x_valid,
    output logic                     x_ready,
    output logic [DATA_W-1:0]        y_data,
    output logic                     y_valid,
    input  logic                     y_ready,
    input  logic                     coef_we,
    input  logic [idx_w(TAPS)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]        coef_wdata,
    output logic                     busy
);

    localparam int IDX_W  = idx_w(TAPS);
    localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int RS     = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

    localparam logic signed [ACC_W:0] RND =
        (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) << RS) : '0;
    localparam logic signed [ACC_W:0] MAXV =
        {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV =
        {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

    fir_state_t state;
    logic       mac_en;
    logic       load_out;
    logic       accept;
    logic       last_tap;
    logic       out_fire;

    logic signed [DATA_W-1:0] x_dl [TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic        [IDX_W-1:0]  idx;
    logic        [DATA_W-1:0] y_q;
    logic                     yv_q;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W:0]    rnd;
    logic signed [ACC_W:0]    shf;
    logic        [DATA_W-1:0] y_sat;

    assign x_ready  = rst_n && (state == IDLE);
    assign accept   = x_valid && x_ready;
    assign last_tap = (idx == IDX_W'(TAPS-1));
    assign out_fire = yv_q && y_ready;
    assign busy     = (state != IDLE);

    fir_filter_param_fsm u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .accept   (accept),
        .last_tap (last_tap),
        .out_fire (out_fire),
        .state    (state),
        .mac_en   (mac_en),
        .load_out (load_out)
    );

    assign prod     = coef[idx] * x_dl[idx];
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) x_dl[i] <= '0;
            acc <= '0;
            idx <= '0;
        end else if (accept) begin
            x_dl[0] <= x_data;
            for (int i = 1; i < TAPS; i++) x_dl[i] <= x_dl[i-1];
            acc <= '0;
            idx <= '0;
        end else if (mac_en) begin
            acc <= acc + prod_ext;
            idx <= idx + IDX_W'(1);
        end
    end

    // Writes land on the accept edge too, so the new value feeds that computation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) coef[i] <= '0;
        end else if (coef_we && state == IDLE && int'(coef_addr) < TAPS) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

    always_comb begin
        rnd   = {acc[ACC_W-1], acc} + RND;
        shf   = rnd >>> OUT_SHIFT;
        y_sat = shf[DATA_W-1:0];
        if (shf > MAXV)      y_sat = MAXV[DATA_W-1:0];
        else if (shf < MINV) y_sat = MINV[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q  <= '0;
            yv_q <= 1'b0;
        end else if (load_out) begin
            y_q  <= y_sat;
            yv_q <= 1'b1;
        end else if (out_fire) begin
            yv_q <= 1'b0;
        end
    end

    assign y_data  = y_q;
    assign y_valid = yv_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Scoreboard bench for fir_filter_param: directed vectors, queued expectations.
module tb_fir_filter_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [15:0] x_data = '0;
    logic        x_valid = 1'b0;
    logic        x_ready;
    logic [15:0] y_data;
    logic        y_valid;
    logic        y_ready = 1'b1;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [15:0] coef_wdata = '0;
    logic        busy;

    logic [15:0] r_x_data = '0;
    logic        r_x_valid = 1'b0;
    logic        r_x_ready;
    logic [15:0] r_y_data;
    logic        r_y_valid;
    logic        r_y_ready = 1'b1;
    logic        r_coef_we = 1'b0;
    logic [3:0]  r_coef_addr = '0;
    logic [15:0] r_coef_wdata = '0;
    logic        r_busy;

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] q  [$];
    logic [15:0] qr [$];
    logic [15:0] e_m;
    logic [15:0] e_r;

    always #5 clk = ~clk;

    fir_filter_param #(
        .DATA_W(16), .COEF_W(16), .TAPS(16), .OUT_SHIFT(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
        .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .busy(busy)
    );

    fir_filter_param #(
        .DATA_W(16), .COEF_W(16), .TAPS(16), .OUT_SHIFT(1)
    ) dut_r (
        .clk(clk), .rst_n(rst_n),
        .x_data(r_x_data), .x_valid(r_x_valid), .x_ready(r_x_ready),
        .y_data(r_y_data), .y_valid(r_y_valid), .y_ready(r_y_ready),
        .coef_we(r_coef_we), .coef_addr(r_coef_addr),
        .coef_wdata(r_coef_wdata), .busy(r_busy)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && y_valid && y_ready) begin
            if (q.size() == 0) begin
                check("unexpected_y", 32'(y_data), 32'hDEAD_0000);
            end else begin
                e_m = q.pop_front();
                check("y_data", 32'(y_data), 32'(e_m));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && r_y_valid && r_y_ready) begin
            if (qr.size() == 0) begin
                check("unexpected_ry", 32'(r_y_data), 32'hDEAD_0000);
            end else begin
                e_r = qr.pop_front();
                check("ry_data", 32'(r_y_data), 32'(e_r));
            end
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] e,
                        input bit push);
        int t = 0;
        @(negedge clk);
        while (!x_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            check("send_timeout", 32'(t), 32'(0));
            return;
        end
        x_data  = x;
        x_valid = 1'b1;
        if (push) q.push_back(e);
        @(posedge clk);
        #1 x_valid = 1'b0;
    endtask

    task automatic rsend(input logic [15:0] x, input logic [15:0] e);
        int t = 0;
        @(negedge clk);
        while (!r_x_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            check("rsend_timeout", 32'(t), 32'(0));
            return;
        end
        r_x_data  = x;
        r_x_valid = 1'b1;
        qr.push_back(e);
        @(posedge clk);
        #1 r_x_valid = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = d;
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || qr.size() != 0 || !x_ready || !r_x_ready)
               && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("drain_timeout", 32'(t), 32'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_y_valid", 32'(y_valid), 32'(0));
        check("rst_y_data", 32'(y_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_x_ready", 32'(x_ready), 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_x_ready", 32'(x_ready), 32'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        bit seen;

        do_reset();

        // Impulse response with c[i] = i+1
        for (int i = 0; i < 16; i++) wr(4'(i), 16'(i + 1));
        send(16'd1, 16'd1, 1'b1);
        n = 0;
        while (!y_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check("latency", 32'(n), 32'(17));
        for (int i = 1; i < 16; i++) send(16'd0, 16'(i + 1), 1'b1);
        send(16'd0, 16'd0, 1'b1);
        drain();

        // Backpressure: history now all zero, c0=1, c1=2
        y_ready = 1'b0;
        send(16'd2, 16'd2, 1'b1);
        n = 0;
        while (!y_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check("bp_latency", 32'(n), 32'(17));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_y_data", 32'(y_data), 32'(2));
            check("bp_y_valid", 32'(y_valid), 32'(1));
            check("bp_x_ready", 32'(x_ready), 32'(0));
        end
        y_ready = 1'b1;
        @(posedge clk);
        #1 check("bp_ready_after", 32'(x_ready), 32'(1));
        send(16'd0, 16'd4, 1'b1);
        check("bp_accept_busy", 32'(busy), 32'(1));
        drain();

        // Saturation in both directions
        for (int i = 0; i < 16; i++) wr(4'(i), 16'h7FFF);
        for (int i = 0; i < 16; i++) send(16'h7FFF, 16'h7FFF, 1'b1);
        for (int k = 1; k <= 16; k++)
            send(16'h8000, (k <= 7) ? 16'h7FFF : 16'h8000, 1'b1);
        drain();

        // Coefficient writes while busy are dropped
        do_reset();
        wr(4'd0, 16'd2);
        send(16'd3, 16'd6, 1'b1);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = 4'd0;
        coef_wdata = 16'd5;
        repeat (3) @(posedge clk);
        #1 coef_we = 1'b0;
        drain();
        wr(4'd0, 16'd5);
        send(16'd1, 16'd5, 1'b1);
        drain();
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = 4'd1;
        coef_wdata = 16'd4;
        x_data     = 16'd2;
        x_valid    = 1'b1;
        q.push_back(16'd14);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        x_valid = 1'b0;
        drain();

        // Reset in the middle of MAC abandons the sample
        send(16'd7, 16'd0, 1'b0);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_y_valid", 32'(y_valid), 32'(0));
        check("midrst_y_data", 32'(y_data), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_x_ready", 32'(x_ready), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (y_valid) seen = 1'b1;
        end
        check("midrst_no_output", 32'(seen), 32'(0));
        send(16'd1, 16'd0, 1'b1);
        drain();

        // Rounding with OUT_SHIFT = 1
        @(negedge clk);
        r_coef_we    = 1'b1;
        r_coef_addr  = 4'd0;
        r_coef_wdata = 16'd3;
        @(posedge clk);
        #1 r_coef_we = 1'b0;
        rsend(16'd1, 16'd2);
        rsend(16'hFFFF, 16'hFFFF);
        rsend(16'd0, 16'd0);
        drain();

        check("queue_empty", 32'(q.size() + qr.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
